// File: rtl/ibex_multdiv_iter_pkg.sv
// Shared types and helpers for the iterative multiplier/divider.
package ibex_multdiv_pkg;

    typedef enum logic [1:0] {
        MD_OP_MUL  = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [2:0] {
        MD_IDLE  = 3'd0,
        MD_PREP  = 3'd1,
        MD_ITER  = 3'd2,
        MD_FIXUP = 3'd3,
        MD_DONE  = 3'd4
    } md_iter_state_e;

    // Width of the iteration counter, which must hold WIDTH/UNROLL.
    function automatic int unsigned md_cnt_width(input int unsigned width,
                                                 input int unsigned unroll);
        return $clog2(width / unroll + 1);
    endfunction

endpackage

// File: rtl/ibex_multdiv_iter_if.sv
// Request/response bundle between the EX stage and the iterative mult/div unit.
interface ibex_multdiv_iter_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             req_valid_i;
    logic             req_ready_o;
    logic [1:0]       operator_i;
    logic [1:0]       signed_mode_i;
    logic [WIDTH-1:0] op_a_i;
    logic [WIDTH-1:0] op_b_i;
    logic             data_ind_timing_i;
    logic             kill_i;
    logic             resp_valid_o;
    logic             resp_ready_i;
    logic [WIDTH-1:0] result_o;
    logic             busy_o;

    modport master (
        output req_valid_i, operator_i, signed_mode_i, op_a_i, op_b_i,
               data_ind_timing_i, kill_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, result_o, busy_o
    );

    modport slave (
        input  req_valid_i, operator_i, signed_mode_i, op_a_i, op_b_i,
               data_ind_timing_i, kill_i, resp_ready_i,
        output req_ready_o, resp_valid_o, result_o, busy_o
    );
endinterface

// File: rtl/ibex_multdiv_iter_step.sv
// One radix-2 step: shift-add for multiply, restoring subtract for divide.
// Divide mode uses the low WIDTH bits of acc as the partial remainder, the
// low WIDTH bits of mcand as the divisor magnitude and mplier as the
// dividend/quotient shift register (dividend out at MSB, quotient in at LSB).
module ibex_multdiv_iter_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               i_div,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [2*WIDTH-1:0] i_mcand,
    input  logic [WIDTH-1:0]   i_mplier,
    output logic [2*WIDTH-1:0] o_acc,
    output logic [2*WIDTH-1:0] o_mcand,
    output logic [WIDTH-1:0]   o_mplier
);
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_rem_diff;
    logic             w_ge;

    // Compute the next accumulator/multiplicand/multiplier for either mode.
    always_comb begin
        w_rem_sh   = {i_acc[WIDTH-1:0], i_mplier[WIDTH-1]};
        // When the subtract is taken the true difference is below the divisor,
        // so the low WIDTH bits are exact.
        w_rem_diff = w_rem_sh[WIDTH-1:0] - i_mcand[WIDTH-1:0];
        w_ge       = (w_rem_sh >= {1'b0, i_mcand[WIDTH-1:0]});
        o_acc      = i_acc;
        o_mcand    = i_mcand;
        o_mplier   = i_mplier;
        if (i_div) begin
            o_acc    = {{WIDTH{1'b0}}, (w_ge ? w_rem_diff : w_rem_sh[WIDTH-1:0])};
            o_mplier = {i_mplier[WIDTH-2:0], w_ge};
        end else begin
            if (i_mplier[0]) begin
                o_acc = i_acc + i_mcand;
            end
            o_mcand  = i_mcand << 1;
            o_mplier = i_mplier >> 1;
        end
    end
endmodule

// File: rtl/ibex_multdiv_iter.sv
// Iterative RV32M/RV64M multiplier/divider retiring UNROLL bits per cycle.
module ibex_multdiv_iter
    import ibex_multdiv_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned UNROLL = 1
) (
    input logic                clk_i,
    input logic                rst_ni,
    ibex_multdiv_iter_if.slave bus
);
    localparam int unsigned CW    = md_cnt_width(WIDTH, UNROLL);
    localparam int unsigned NSTEP = WIDTH / UNROLL;

    md_iter_state_e     r_state;
    md_op_e             r_op;
    logic               r_sa;
    logic               r_sb;
    logic               r_dit;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_resp_valid;
    logic               r_busy;

    logic               w_is_div;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fix_result;

    logic [2*WIDTH-1:0] w_acc_c    [UNROLL+1];
    logic [2*WIDTH-1:0] w_mcand_c  [UNROLL+1];
    logic [WIDTH-1:0]   w_mplier_c [UNROLL+1];

    assign w_is_div = (r_op == MD_OP_DIV) || (r_op == MD_OP_REM);
    assign w_abs_a  = r_sa ? (~r_a + 1'b1) : r_a;
    assign w_abs_b  = r_sb ? (~r_b + 1'b1) : r_b;

    assign bus.req_ready_o  = (r_state == MD_IDLE) & ~bus.kill_i;
    assign bus.resp_valid_o = r_resp_valid;
    assign bus.result_o     = r_result;
    assign bus.busy_o       = r_busy;

    assign w_acc_c[0]    = r_acc;
    assign w_mcand_c[0]  = r_mcand;
    assign w_mplier_c[0] = r_mplier;

    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        ibex_multdiv_iter_step #(.WIDTH(WIDTH)) u_step (
            .i_div    (w_is_div),
            .i_acc    (w_acc_c[g]),
            .i_mcand  (w_mcand_c[g]),
            .i_mplier (w_mplier_c[g]),
            .o_acc    (w_acc_c[g+1]),
            .o_mcand  (w_mcand_c[g+1]),
            .o_mplier (w_mplier_c[g+1])
        );
    end

    // Sign correction and word selection applied in FIXUP.
    always_comb begin
        w_prod = (r_sa ^ r_sb) ? (~r_acc + 1'b1) : r_acc;
        unique case (r_op)
            MD_OP_MUL:  w_fix_result = w_prod[WIDTH-1:0];
            MD_OP_MULH: w_fix_result = w_prod[2*WIDTH-1:WIDTH];
            MD_OP_DIV:  w_fix_result = ((r_sa ^ r_sb) && (r_b != '0)) ?
                                       (~r_mplier + 1'b1) : r_mplier;
            default:    w_fix_result = r_sa ? (~r_acc[WIDTH-1:0] + 1'b1) :
                                       r_acc[WIDTH-1:0];
        endcase
    end

    // Control FSM and datapath registers; kill overrides every state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= MD_IDLE;
            r_op         <= MD_OP_MUL;
            r_sa         <= 1'b0;
            r_sb         <= 1'b0;
            r_dit        <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_cnt        <= '0;
            r_result     <= '0;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else if (bus.kill_i) begin
            r_state      <= MD_IDLE;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            unique case (r_state)
                MD_IDLE: begin
                    if (bus.req_valid_i) begin
                        r_op    <= md_op_e'(bus.operator_i);
                        r_sa    <= bus.op_a_i[WIDTH-1] & bus.signed_mode_i[0];
                        r_sb    <= bus.op_b_i[WIDTH-1] & bus.signed_mode_i[1];
                        r_dit   <= bus.data_ind_timing_i;
                        r_a     <= bus.op_a_i;
                        r_b     <= bus.op_b_i;
                        r_busy  <= 1'b1;
                        r_state <= MD_PREP;
                    end
                end
                MD_PREP: begin
                    r_cnt <= CW'(NSTEP);
                    r_acc <= '0;
                    if (w_is_div) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_abs_b};
                        r_mplier <= w_abs_a;
                    end else begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
                        r_mplier <= w_abs_b;
                    end
                    if (!r_dit && (w_abs_b == '0)) begin
                        // Preload what a full zero-divisor run would leave
                        // behind: quotient all-ones, remainder |a|.
                        if (w_is_div) begin
                            r_acc    <= {{WIDTH{1'b0}}, w_abs_a};
                            r_mplier <= '1;
                        end
                        r_state <= MD_FIXUP;
                    end else begin
                        r_state <= MD_ITER;
                    end
                end
                MD_ITER: begin
                    r_acc    <= w_acc_c[UNROLL];
                    r_mcand  <= w_mcand_c[UNROLL];
                    r_mplier <= w_mplier_c[UNROLL];
                    r_cnt    <= r_cnt - 1'b1;
                    if ((r_cnt == CW'(1)) ||
                        (!r_dit && !w_is_div && (w_mplier_c[UNROLL] == '0))) begin
                        r_state <= MD_FIXUP;
                    end
                end
                MD_FIXUP: begin
                    r_result     <= w_fix_result;
                    r_resp_valid <= 1'b1;
                    r_state      <= MD_DONE;
                end
                MD_DONE: begin
                    if (bus.resp_ready_i) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= MD_IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= MD_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Scoreboard bench for ibex_multdiv_iter with UNROLL=1 and UNROLL=4 instances.
module tb_ibex_multdiv_iter;
    import ibex_multdiv_pkg::*;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ibex_multdiv_iter_if #(.WIDTH(W)) if1 ();
    ibex_multdiv_iter_if #(.WIDTH(W)) if4 ();

    ibex_multdiv_iter #(.WIDTH(W), .UNROLL(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if1.slave));
    ibex_multdiv_iter #(.WIDTH(W), .UNROLL(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if4.slave));

    int unsigned  sel;
    logic         d_req_valid, d_kill, d_resp_ready, d_dit;
    logic [1:0]   d_op, d_sm;
    logic [W-1:0] d_a, d_b;

    assign if1.req_valid_i       = d_req_valid && (sel == 0);
    assign if4.req_valid_i       = d_req_valid && (sel == 1);
    assign if1.kill_i            = d_kill && (sel == 0);
    assign if4.kill_i            = d_kill && (sel == 1);
    assign if1.resp_ready_i      = d_resp_ready || (sel != 0);
    assign if4.resp_ready_i      = d_resp_ready || (sel != 1);
    assign if1.operator_i        = d_op;
    assign if4.operator_i        = d_op;
    assign if1.signed_mode_i     = d_sm;
    assign if4.signed_mode_i     = d_sm;
    assign if1.op_a_i            = d_a;
    assign if4.op_a_i            = d_a;
    assign if1.op_b_i            = d_b;
    assign if4.op_b_i            = d_b;
    assign if1.data_ind_timing_i = d_dit;
    assign if4.data_ind_timing_i = d_dit;

    logic         o_req_ready, o_resp_valid, o_busy;
    logic [W-1:0] o_result;
    assign o_req_ready  = (sel == 0) ? if1.req_ready_o  : if4.req_ready_o;
    assign o_resp_valid = (sel == 0) ? if1.resp_valid_o : if4.resp_valid_o;
    assign o_busy       = (sel == 0) ? if1.busy_o       : if4.busy_o;
    assign o_result     = (sel == 0) ? if1.result_o     : if4.result_o;

    typedef struct {
        logic [W-1:0] res;
        int unsigned  lat;
    } exp_t;
    exp_t sb_q[$];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_res(input logic [1:0] op, input logic [1:0] sm,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0]  ea, eb, p;
        logic [W-1:0] q, r;
        ea = sm[0] ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sm[1] ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (sm == 2'b11) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = '0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        case (op)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return q;
            default: return r;
        endcase
    endfunction

    function automatic int unsigned ref_lat(input logic [1:0] op, input logic [1:0] sm,
                                            input logic [W-1:0] b, input logic dit,
                                            input int unsigned u);
        logic [W-1:0] bm;
        int unsigned  bits;
        bm = (sm[1] && b[31]) ? (~b + 1) : b;
        if (dit) return W / u + 2;
        if (bm == '0) return 2;
        if (op >= 2) return W / u + 2;
        bits = 0;
        for (int i = 0; i < W; i++) if (bm[i]) bits = i + 1;
        return 2 + (bits + u - 1) / u;
    endfunction

    task automatic run(input int unsigned s, input string tag, input logic [1:0] op,
                       input logic [1:0] sm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic dit, input logic stall);
        exp_t         e;
        int unsigned  n;
        logic         got_resp;
        logic [W-1:0] held;
        sel   = s;
        e.res = ref_res(op, sm, a, b);
        e.lat = ref_lat(op, sm, b, dit, (s == 0) ? 1 : 4);
        sb_q.push_back(e);
        @(negedge clk);
        chk({tag, ":rdy"}, {63'b0, o_req_ready}, 64'd1);
        d_op = op; d_sm = sm; d_a = a; d_b = b; d_dit = dit;
        d_resp_ready = !stall;
        d_req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_req_valid = 1'b0;
        n = 0;
        got_resp = 1'b0;
        while (!got_resp && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            got_resp = o_resp_valid;
        end
        e = sb_q.pop_front();
        chk({tag, ":resp"}, {63'b0, got_resp}, 64'd1);
        chk({tag, ":lat"}, 64'(n), 64'(e.lat));
        chk({tag, ":res"}, 64'(o_result), 64'(e.res));
        if (stall) begin
            held = o_result;
            repeat (5) begin
                @(posedge clk);
                @(negedge clk);
                chk({tag, ":hold"}, 64'(o_result), 64'(held));
                chk({tag, ":hold_rdy"}, {63'b0, o_req_ready}, 64'd0);
                chk({tag, ":hold_vld"}, {63'b0, o_resp_valid}, 64'd1);
            end
            d_resp_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, ":release"}, {63'b0, o_resp_valid}, 64'd0);
    endtask

    initial begin
        logic        seen;
        logic [1:0]  rop, rsm;
        logic [W-1:0] ra, rb;
        sel = 0;
        d_req_valid = 0; d_kill = 0; d_resp_ready = 1; d_dit = 0;
        d_op = 0; d_sm = 0; d_a = 0; d_b = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int unsigned s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk("rst:vld", {63'b0, o_resp_valid}, 64'd0);
            chk("rst:busy", {63'b0, o_busy}, 64'd0);
            chk("rst:res", 64'(o_result), 64'd0);
            chk("rst:rdy", {63'b0, o_req_ready}, 64'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        run(0, "mul_7x-3",   2'd0, 2'b11, 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0);
        run(0, "mulh_7x-3",  2'd1, 2'b11, 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0);
        run(0, "mulh_uu",    2'd1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run(0, "mulh_su",    2'd1, 2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        run(0, "div_-7/2",   2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run(0, "rem_-7/2",   2'd3, 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run(1, "div4_-7/2",  2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run(1, "rem4_-7/2",  2'd3, 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run(0, "div_ovf",    2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run(0, "rem_ovf",    2'd3, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        for (int unsigned k = 0; k < 2; k++) begin
            run(0, "div_by0",  2'd2, 2'b00, 32'd5, 32'd0, k[0], 1'b0);
            run(0, "rem_by0",  2'd3, 2'b00, 32'd5, 32'd0, k[0], 1'b0);
            run(0, "mul_3x16", 2'd0, 2'b00, 32'd3, 32'h10, k[0], 1'b0);
        end
        run(1, "rem4_by0_s", 2'd3, 2'b11, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0);
        run(1, "mul4_3x16",  2'd0, 2'b00, 32'd3, 32'h10, 1'b0, 1'b0);
        run(0, "stall_div",  2'd2, 2'b00, 32'd1000, 32'd7, 1'b0, 1'b1);

        // Kill in the middle of ITER.
        sel = 0;
        @(negedge clk);
        d_op = 2'd0; d_sm = 2'b00; d_a = 32'd123; d_b = 32'hFFFF_FFFF; d_dit = 1'b1;
        d_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_req_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("kill:busy_before", {63'b0, o_busy}, 64'd1);
        d_kill = 1'b1;
        d_req_valid = 1'b1;
        #1;
        chk("kill:rdy_low", {63'b0, o_req_ready}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        d_kill = 1'b0;
        d_req_valid = 1'b0;
        chk("kill:vld", {63'b0, o_resp_valid}, 64'd0);
        chk("kill:busy", {63'b0, o_busy}, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen = seen | o_resp_valid | o_busy;
        end
        chk("kill:quiet", {63'b0, seen}, 64'd0);
        run(0, "mul_6x7", 2'd0, 2'b00, 32'd6, 32'd7, 1'b0, 1'b0);

        for (int unsigned i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            rsm = 2'($urandom_range(0, 3));
            if (rop >= 2) rsm = rsm[0] ? 2'b11 : 2'b00;
            ra = $urandom;
            rb = (i % 4 == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
            run(i % 2, "rand", rop, rsm, ra, rb, 1'($urandom_range(0, 1)), 1'b0);
        end

        // Asynchronous reset in the middle of an operation.
        sel = 1;
        @(negedge clk);
        d_op = 2'd2; d_sm = 2'b00; d_a = 32'd99; d_b = 32'd4; d_dit = 1'b0;
        d_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst:vld", {63'b0, o_resp_valid}, 64'd0);
        chk("midrst:busy", {63'b0, o_busy}, 64'd0);
        chk("midrst:res", 64'(o_result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(1, "post_rst", 2'd3, 2'b00, 32'd99, 32'd4, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
